// File: rtl/genie_pkg.sv
// Shared widths, instruction field positions, opcodes and FSM state type for the Genie core.
package genie_pkg;

  localparam int IADDR_W = 13;
  localparam int DADDR_W = 26;
  localparam int DATA_W  = 32;
  localparam int NREG    = 16;
  localparam int RSEL_W  = 4;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RS1_HI = 23;
  localparam int RS1_LO = 20;
  localparam int RS2_HI = 19;
  localparam int RS2_LO = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Opcodes; 10..14 are unassigned and behave as NOP
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_MAC  = 4'd4;
  localparam logic [3:0] OP_RELU = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BNE  = 4'd8;
  localparam logic [3:0] OP_LUI  = 4'd9;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_LOAD  = 3'd2,
    S_STORE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Sign-extend a 16-bit immediate to the data width.
  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
    return {{(DATA_W-16){v[15]}}, v};
  endfunction

endpackage

// File: rtl/genie_if.sv
// Instruction-ROM and data-SRAM bus of the Genie core; the core is master, memories are slave.
interface genie_if;
  import genie_pkg::*;

  logic [IADDR_W-1:0] iaddr;
  logic [DATA_W-1:0]  idata;

  logic               rvalid;
  logic               rready;
  logic [DADDR_W-1:0] raddr;
  logic [DATA_W-1:0]  rdata;

  logic               wvalid;
  logic               wready;
  logic [DADDR_W-1:0] waddr;
  logic [DATA_W-1:0]  wdata;

  modport master (
    output iaddr, rvalid, raddr, wvalid, waddr, wdata,
    input  idata, rready, rdata, wready
  );

  modport slave (
    input  iaddr, rvalid, raddr, wvalid, waddr, wdata,
    output idata, rready, rdata, wready
  );

endinterface

// File: rtl/genie_regfile.sv
// 16x32 register file: asynchronous reads, one synchronous write, r0 hardwired to zero.
module genie_regfile
  import genie_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RSEL_W-1:0] sel_a,
  output logic [DATA_W-1:0] val_a,
  input  logic [RSEL_W-1:0] sel_b,
  output logic [DATA_W-1:0] val_b,
  // Port C supplies the MAC accumulator (rd), the third operand needed in the same cycle.
  input  logic [RSEL_W-1:0] sel_c,
  output logic [DATA_W-1:0] val_c,
  input  logic              we,
  input  logic [RSEL_W-1:0] wsel,
  input  logic [DATA_W-1:0] wval
);

  logic [DATA_W-1:0] regs [NREG];

  // Clear everything on reset; writes to r0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (wsel != '0)) begin
      regs[wsel] <= wval;
    end
  end

  assign val_a = (sel_a == '0) ? '0 : regs[sel_a];
  assign val_b = (sel_b == '0) ? '0 : regs[sel_b];
  assign val_c = (sel_c == '0) ? '0 : regs[sel_c];

endmodule

// File: rtl/genie_core.sv
// Genie compute core: fetch/execute FSM, ALU and load/store handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// FETCH   | iaddr=pc presented to ROM; idata is valid next cycle
// EXEC    | decode idata, ALU write-back / branch, or launch LD/ST/HALT
// LOAD    | rvalid held with raddr until rready; rdata written to rd
// STORE   | wvalid held with waddr/wdata until wready
// HALT    | terminal until reset; done=1, iaddr holds the HALT pc
module genie_core
  import genie_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  genie_if.master  bus,
  output logic     done
);

  localparam logic [IADDR_W-1:0] PC_ONE = IADDR_W'(1);

  state_t             state;
  logic [IADDR_W-1:0] pc;
  logic [RSEL_W-1:0]  ld_rd;

  logic [3:0]         f_op;
  logic [RSEL_W-1:0]  f_rd;
  logic [RSEL_W-1:0]  f_rs1;
  logic [RSEL_W-1:0]  f_rs2;
  logic [15:0]        f_imm;
  logic [DATA_W-1:0]  simm;

  logic [DATA_W-1:0]  rs1_val;
  logic [DATA_W-1:0]  rs2_val;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  prod;
  logic [DATA_W-1:0]  alu_res;
  logic [DADDR_W-1:0] ea;
  logic [IADDR_W-1:0] br_target;

  logic               rf_we;
  logic [RSEL_W-1:0]  rf_wsel;
  logic [DATA_W-1:0]  rf_wval;

  assign f_op  = bus.idata[OP_HI:OP_LO];
  assign f_rd  = bus.idata[RD_HI:RD_LO];
  assign f_rs1 = bus.idata[RS1_HI:RS1_LO];
  assign f_rs2 = bus.idata[RS2_HI:RS2_LO];
  assign f_imm = bus.idata[IMM_HI:IMM_LO];
  assign simm  = sext16(f_imm);

  assign bus.iaddr = pc;

  genie_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .sel_a (f_rs1),
    .val_a (rs1_val),
    .sel_b (f_rs2),
    .val_b (rs2_val),
    .sel_c (f_rd),
    .val_c (rd_val),
    .we    (rf_we),
    .wsel  (rf_wsel),
    .wval  (rf_wval)
  );

  // Low 32 bits of a product are identical for signed and unsigned operands.
  assign prod      = rs1_val * rs2_val;
  assign ea        = rs1_val[DADDR_W-1:0] + simm[DADDR_W-1:0];
  assign br_target = pc + simm[IADDR_W-1:0];

  // ALU result for register-writing opcodes.
  always_comb begin
    alu_res = '0;
    case (f_op)
      OP_ADDI: alu_res = rs1_val + simm;
      OP_ADD:  alu_res = rs1_val + rs2_val;
      OP_MUL:  alu_res = prod;
      OP_MAC:  alu_res = rd_val + prod;
      OP_RELU: alu_res = rs1_val[DATA_W-1] ? '0 : rs1_val;
      OP_LUI:  alu_res = {f_imm, 16'h0000};
      default: alu_res = '0;
    endcase
  end

  // Register write-back: ALU results in EXEC, load data in the accepting LOAD cycle.
  always_comb begin
    rf_we   = 1'b0;
    rf_wsel = f_rd;
    rf_wval = alu_res;
    if (state == S_EXEC) begin
      case (f_op)
        OP_ADDI, OP_ADD, OP_MUL, OP_MAC, OP_RELU, OP_LUI: rf_we = 1'b1;
        default: rf_we = 1'b0;
      endcase
    end else if ((state == S_LOAD) && bus.rready) begin
      rf_we   = 1'b1;
      rf_wsel = ld_rd;
      rf_wval = bus.rdata;
    end
  end

  // Main sequencer with registered bus outputs and done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= '0;
      ld_rd      <= '0;
      bus.rvalid <= 1'b0;
      bus.raddr  <= '0;
      bus.wvalid <= 1'b0;
      bus.waddr  <= '0;
      bus.wdata  <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC;

        S_EXEC: begin
          ld_rd <= f_rd;
          case (f_op)
            OP_LD: begin
              bus.rvalid <= 1'b1;
              bus.raddr  <= ea;
              state      <= S_LOAD;
            end
            OP_ST: begin
              bus.wvalid <= 1'b1;
              bus.waddr  <= ea;
              bus.wdata  <= rs2_val;
              state      <= S_STORE;
            end
            OP_BNE: begin
              pc    <= (rs1_val != rs2_val) ? br_target : pc + PC_ONE;
              state <= S_FETCH;
            end
            OP_HALT: begin
              done  <= 1'b1;
              state <= S_HALT;
            end
            default: begin
              pc    <= pc + PC_ONE;
              state <= S_FETCH;
            end
          endcase
        end

        S_LOAD: begin
          if (bus.rready) begin
            bus.rvalid <= 1'b0;
            pc         <= pc + PC_ONE;
            state      <= S_FETCH;
          end
        end

        S_STORE: begin
          if (bus.wready) begin
            bus.wvalid <= 1'b0;
            pc         <= pc + PC_ONE;
            state      <= S_FETCH;
          end
        end

        S_HALT: state <= S_HALT;

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_genie_core.sv
// Self-checking bench for genie_core: ROM/SRAM models, scoreboard queues for reads, writes and pc trace.
module tb_genie_core;
  import genie_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done;

  genie_if bus ();

  genie_core dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .done (done)
  );

  always #5 clk = ~clk;

  logic [31:0] rom [0:8191];
  logic [31:0] dmem [logic [25:0]];

  // Synchronous ROM: idata valid the cycle after iaddr is sampled.
  always @(posedge clk) bus.idata <= rom[bus.iaddr];

  logic [25:0] rq [$];
  logic [57:0] wq [$];
  logic [12:0] pq [$];

  int total = 0;
  int bad   = 0;
  int rdelay = 1;
  int wdelay = 1;
  bit pc_track = 1'b0;

  int          rcnt = 0;
  int          wcnt = 0;
  bit          racc = 1'b0;
  bit          wacc = 1'b0;
  logic [25:0] rfirst;
  logic [57:0] wfirst;
  logic [12:0] last_pc = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [31:0] st(input logic [3:0] base, input logic [3:0] src,
                                     input logic [15:0] off);
    return enc(OP_ST, 4'd0, base, src, off);
  endfunction

  task automatic clear_all();
    for (int i = 0; i < 8192; i++) rom[i] = 32'h0;
    dmem.delete();
    rq.delete();
    wq.delete();
    pq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_iaddr",  32'(bus.iaddr),  32'h0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rst_wvalid", 32'(bus.wvalid), 32'h0);
    chk("rst_raddr",  32'(bus.raddr),  32'h0);
    chk("rst_waddr",  32'(bus.waddr),  32'h0);
    chk("rst_wdata",  bus.wdata,       32'h0);
    chk("rst_done",   32'(done),       32'h0);
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done", 32'(done), 32'h1);
    chk("rd_left", rq.size(), 32'h0);
    chk("wr_left", wq.size(), 32'h0);
    if (pc_track) chk("pc_left", pq.size(), 32'h0);
  endtask

  // Memory responder and bus monitor, driven on the falling edge.
  initial begin : responder
    bus.rready = 1'b0;
    bus.wready = 1'b0;
    bus.rdata  = 32'h0;
    forever begin
      @(negedge clk);
      bus.rready = 1'b0;
      bus.wready = 1'b0;
      bus.rdata  = 32'hBAD0_0000;
      if (rst) begin
        rcnt = 0; wcnt = 0; racc = 1'b0; wacc = 1'b0;
      end else begin
        if (racc) chk("rvalid_drop", 32'(bus.rvalid), 32'h0);
        if (wacc) chk("wvalid_drop", 32'(bus.wvalid), 32'h0);
        racc = 1'b0;
        wacc = 1'b0;
        if (bus.rvalid || bus.wvalid) chk("one_txn", 32'(bus.rvalid & bus.wvalid), 32'h0);
        if (!bus.rvalid && rcnt > 0) begin
          chk("rvalid_held", 32'(bus.rvalid), 32'h1);
          rcnt = 0;
        end
        if (!bus.wvalid && wcnt > 0) begin
          chk("wvalid_held", 32'(bus.wvalid), 32'h1);
          wcnt = 0;
        end
        if (bus.rvalid) begin
          rcnt++;
          if (rcnt == 1) begin
            rfirst = bus.raddr;
            if (rq.size() == 0) chk("rd_unexp", rq.size(), 32'h1);
            else chk("raddr", 32'(bus.raddr), 32'(rq[0]));
          end else begin
            chk("raddr_hold", 32'(bus.raddr), 32'(rfirst));
          end
          if (rcnt >= rdelay) begin
            bus.rready = 1'b1;
            bus.rdata  = dmem.exists(bus.raddr) ? dmem[bus.raddr] : 32'h0;
            if (rq.size() > 0) void'(rq.pop_front());
            racc = 1'b1;
            rcnt = 0;
          end
        end
        if (bus.wvalid) begin
          wcnt++;
          if (wcnt == 1) begin
            wfirst = {bus.waddr, bus.wdata};
            if (wq.size() == 0) chk("wr_unexp", wq.size(), 32'h1);
            else begin
              chk("waddr", 32'(bus.waddr), 32'(wq[0][57:32]));
              chk("wdata", bus.wdata, wq[0][31:0]);
            end
          end else begin
            chk("wreq_hold", 32'({bus.waddr, bus.wdata} != wfirst), 32'h0);
          end
          if (wcnt >= wdelay) begin
            bus.wready = 1'b1;
            if (wq.size() > 0) void'(wq.pop_front());
            wacc = 1'b1;
            wcnt = 0;
          end
        end
        if (pc_track && (bus.iaddr != last_pc)) begin
          if (pq.size() == 0) chk("pc_extra", pq.size(), 32'h1);
          else chk("pc_seq", 32'(bus.iaddr), 32'(pq.pop_front()));
        end
      end
      last_pc = rst ? 13'h0 : bus.iaddr;
    end
  end

  initial begin : main
    int n;
    logic [12:0] t5 [$];
    logic [12:0] t6 [$];

    // T1: ADDI/ADDI/MUL/HALT timing and HALT hold
    clear_all();
    rdelay = 1; wdelay = 1; pc_track = 1'b0;
    rom[0] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd5);
    rom[1] = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    rom[2] = enc(OP_MUL,  4'd3, 4'd1, 4'd2, 16'd0);
    rom[3] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) chk("done_early", 32'(done), 32'h0);
    end
    chk("done_at_8", 32'(done), 32'h1);
    repeat (5) @(negedge clk);
    chk("halt_iaddr", 32'(bus.iaddr), 32'h3);
    chk("done_hold", 32'(done), 32'h1);
    wait_done(10);

    // T2: MUL result, RELU, r0 write discard, ADD, unassigned opcode
    clear_all();
    rdelay = 1; wdelay = 3; pc_track = 1'b0;
    rom[0]  = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd5);
    rom[1]  = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    rom[2]  = enc(OP_MUL,  4'd3, 4'd1, 4'd2, 16'd0);
    rom[3]  = st(4'd0, 4'd3, 16'h003F);
    rom[4]  = enc(OP_LUI,  4'd1, 4'd0, 4'd0, 16'h8000);
    rom[5]  = enc(OP_RELU, 4'd4, 4'd1, 4'd0, 16'd0);
    rom[6]  = st(4'd0, 4'd4, 16'h0040);
    rom[7]  = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd7);
    rom[8]  = enc(OP_RELU, 4'd4, 4'd1, 4'd0, 16'd0);
    rom[9]  = st(4'd0, 4'd4, 16'h0041);
    rom[10] = enc(OP_ADDI, 4'd0, 4'd0, 4'd0, 16'd9);
    rom[11] = st(4'd0, 4'd0, 16'h0042);
    rom[12] = enc(OP_ADD,  4'd5, 4'd1, 4'd1, 16'd0);
    rom[13] = enc(4'd12,   4'd5, 4'd1, 4'd1, 16'd0);
    rom[14] = st(4'd0, 4'd5, 16'h0043);
    rom[15] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    wq.push_back({26'h3F, 32'hFFFF_FFF1});
    wq.push_back({26'h40, 32'h0000_0000});
    wq.push_back({26'h41, 32'h0000_0007});
    wq.push_back({26'h42, 32'h0000_0000});
    wq.push_back({26'h43, 32'h0000_000E});
    do_reset();
    wait_done(200);

    // T3: loads with delayed rready, base+negative offset
    clear_all();
    rdelay = 3; wdelay = 1; pc_track = 1'b0;
    dmem[26'h10] = 32'hDEAD_BEEF;
    rom[0] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'h0012);
    rom[1] = enc(OP_LD,   4'd5, 4'd0, 4'd0, 16'h0010);
    rom[2] = st(4'd0, 4'd5, 16'h0011);
    rom[3] = enc(OP_LD,   4'd6, 4'd1, 4'd0, 16'hFFFE);
    rom[4] = st(4'd1, 4'd6, 16'h0100);
    rom[5] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    rq.push_back(26'h10);
    rq.push_back(26'h10);
    wq.push_back({26'h11,  32'hDEAD_BEEF});
    wq.push_back({26'h112, 32'hDEAD_BEEF});
    do_reset();
    wait_done(200);

    // T4: store with immediate wready, address truncated to 26 bits
    clear_all();
    rdelay = 1; wdelay = 1; pc_track = 1'b0;
    rom[0] = enc(OP_LUI,  4'd6, 4'd0, 4'd0, 16'h1234);
    rom[1] = enc(OP_ADDI, 4'd6, 4'd6, 4'd0, 16'h5678);
    rom[2] = st(4'd0, 4'd6, 16'h0020);
    rom[3] = st(4'd6, 4'd6, 16'h0000);
    rom[4] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    wq.push_back({26'h20,      32'h1234_5678});
    wq.push_back({26'h234_5678, 32'h1234_5678});
    do_reset();
    wait_done(100);

    // T5: MAC loop with BNE back-edge, pc trace
    clear_all();
    rdelay = 1; wdelay = 1; pc_track = 1'b1;
    rom[0] = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd3);
    rom[1] = enc(OP_MAC,  4'd2, 4'd1, 4'd1, 16'd0);
    rom[2] = enc(OP_ADDI, 4'd1, 4'd1, 4'd0, 16'hFFFF);
    rom[3] = enc(OP_BNE,  4'd0, 4'd1, 4'd0, 16'hFFFE);
    rom[4] = st(4'd0, 4'd2, 16'h0030);
    rom[5] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    wq.push_back({26'h30, 32'd14});
    t5 = '{13'd1, 13'd2, 13'd3, 13'd1, 13'd2, 13'd3, 13'd1, 13'd2, 13'd3, 13'd4, 13'd5};
    foreach (t5[i]) pq.push_back(t5[i]);
    do_reset();
    wait_done(200);

    // T6: BNE at pc 0 with simm=-1 wraps to 8191
    clear_all();
    rdelay = 1; wdelay = 1; pc_track = 1'b1;
    rom[0]    = enc(OP_BNE,  4'd0, 4'd1, 4'd0, 16'hFFFF);
    rom[1]    = enc(OP_ADDI, 4'd2, 4'd2, 4'd0, 16'd1);
    rom[2]    = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd1);
    rom[3]    = enc(OP_ADDI, 4'd3, 4'd0, 4'd0, 16'd2);
    rom[4]    = enc(OP_BNE,  4'd0, 4'd2, 4'd3, 16'hFFFC);
    rom[5]    = st(4'd0, 4'd2, 16'h0050);
    rom[6]    = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    rom[8191] = enc(OP_ADD,  4'd1, 4'd0, 4'd0, 16'd0);
    wq.push_back({26'h50, 32'd2});
    t6 = '{13'd1, 13'd2, 13'd3, 13'd4, 13'd0, 13'd8191, 13'd0,
           13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6};
    foreach (t6[i]) pq.push_back(t6[i]);
    do_reset();
    wait_done(200);

    // T7: reset while a load is pending
    clear_all();
    rdelay = 50; wdelay = 1; pc_track = 1'b0;
    dmem[26'h10] = 32'hDEAD_BEEF;
    rom[0] = enc(OP_ADDI, 4'd7, 4'd0, 4'd0, 16'h0055);
    rom[1] = enc(OP_LD,   4'd5, 4'd0, 4'd0, 16'h0010);
    rq.push_back(26'h10);
    do_reset();
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ld_start", 32'(bus.rvalid), 32'h1);
    repeat (2) @(negedge clk);
    chk("ld_pending", 32'(bus.rvalid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(bus.rvalid), 32'h0);
    chk("mid_rst_raddr",  32'(bus.raddr),  32'h0);
    chk("mid_rst_iaddr",  32'(bus.iaddr),  32'h0);
    clear_all();
    rdelay = 1; pc_track = 1'b1;
    rom[0] = st(4'd0, 4'd7, 16'h0060);
    rom[1] = st(4'd0, 4'd5, 16'h0061);
    rom[2] = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
    wq.push_back({26'h60, 32'h0});
    wq.push_back({26'h61, 32'h0});
    pq.push_back(13'd1);
    pq.push_back(13'd2);
    @(negedge clk);
    rst = 1'b0;
    wait_done(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
